sram_mem_ctrl: RTL and testbench

- Multi-cycle memory-stage controller. It replaces the single-cycle data memory behind the MEM stage with an external narrow SRAM that has wait states.
- Each pipeline word access is split into BEATS = DATA_W/SRAM_W device beats, and each beat is held for WAIT_CYC cycles.
- It drives `ready` low while an access is in flight. The pipeline top ORs `~ready` into the global freeze so that IF, ID, EXE and MEM all hold.

---
 rtl/sram_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage controller: splits each pipeline word access into
// narrow SRAM beats, each held for WAIT_CYC cycles, and freezes the pipeline meanwhile.
module sram_mem_ctrl #(
  parameter int DATA_W    = 32,
  parameter int SRAM_W    = 16,
  parameter int SRAM_AW   = 18,
  parameter int WAIT_CYC  = 3,
  parameter int BASE_ADDR = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_W-1:0]  sram_wdata,
  input  logic [SRAM_W-1:0]  sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int BEATS   = DATA_W / SRAM_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCNT_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic                op_wr;
  logic [SRAM_AW-1:0]  base, base_in;
  logic [DATA_W-1:0]   wdata_lat;
  logic [SRAM_W-1:0]   wdata_nxt;
  logic [31:0]         word_idx;
  logic                req, wait_last, beat_last;

  assign req       = wr_en | rd_en;
  // Low byte-offset bits fall off the shift; the SRAM address wraps silently.
  assign word_idx  = (address - 32'(BASE_ADDR)) >> BYTE_SH;
  assign base_in   = SRAM_AW'(word_idx * 32'(BEATS));
  assign wait_last = (wcnt == WCNT_W'(WAIT_CYC - 1));
  assign beat_last = (beat == BEAT_W'(BEATS - 1));
  assign beat_nxt  = beat + BEAT_W'(1);
  assign wdata_nxt = SRAM_W'(wdata_lat >> (int'(beat_nxt) * SRAM_W));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: if (wait_last && beat_last) state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes are registered and loaded one edge ahead of the beat they drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      wcnt       <= '0;
      op_wr      <= 1'b0;
      base       <= '0;
      wdata_lat  <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr      <= wr_en;
            base       <= base_in;
            wdata_lat  <= write_data;
            beat       <= '0;
            wcnt       <= '0;
            sram_addr  <= base_in;
            sram_wdata <= write_data[SRAM_W-1:0];
            sram_we_n  <= ~wr_en;
            sram_oe_n  <= wr_en;
          end
        end
        ACCESS: begin
          if (!wait_last) begin
            wcnt <= wcnt + WCNT_W'(1);
          end else begin
            wcnt <= '0;
            if (!op_wr) read_data[int'(beat)*SRAM_W +: SRAM_W] <= sram_rdata;
            if (beat_last) begin
              beat      <= '0;
              sram_we_n <= 1'b1;
              sram_oe_n <= 1'b1;
            end else begin
              beat       <= beat_nxt;
              sram_addr  <= base + SRAM_AW'(beat_nxt);
              sram_wdata <= wdata_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: a cycle-indexed access model checked every cycle,
// directed scenarios with literal expectations, and a 32-bit single-wait instance.
module tb_sram_mem_ctrl;

  localparam int W = 3;
  localparam int N = 6;

  logic        clk, rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_oe_n;

  logic        wr2, rd2;
  logic [31:0] addr2, wdata2, rdata_out2, sram_wdata2, sram_rdata2;
  logic        ready2, we2, oe2;
  logic [17:0] sram_addr2;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 0;

  sram_mem_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_mem_ctrl #(.DATA_W(32), .SRAM_W(32), .WAIT_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2),
    .write_data(wdata2), .read_data(rdata_out2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2),
    .sram_we_n(we2), .sram_oe_n(oe2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Narrow SRAM device behind the default instance
  logic [15:0] sram_mem [0:255];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_wdata;
  assign sram_rdata  = sram_oe_n ? 16'hFFFF : sram_mem[sram_addr[7:0]];
  assign sram_rdata2 = oe2 ? 32'h0 : 32'hCAFEF00D;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m = 0 idle, 1..N access cycle number, N+1 the ready cycle
  int          m;
  logic        mop_wr;
  logic [31:0] maddr, mdata, exp_rd;
  logic [15:0] exp_mem [0:255];

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'd1024) >> 2);
  endfunction

  initial begin
    m = 0;
    exp_rd = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m = 0;
        exp_rd = 0;
      end else if (m == 0) begin
        if (wr_en || rd_en) begin
          mop_wr = wr_en;
          maddr  = address;
          mdata  = write_data;
          m = 1;
        end
      end else if (m <= N) begin
        if (m % W == 0) begin
          int b;
          int wi;
          b  = (m - 1) / W;
          wi = (widx(maddr) * 2 + b) & 255;
          if (mop_wr) exp_mem[wi] = 16'(mdata >> (b * 16));
          else        exp_rd[b*16 +: 16] = exp_mem[wi];
        end
        m++;
      end else begin
        m = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on && !rst) begin
        if (m == 0) check("ready", ready, !(wr_en || rd_en));
        else        check("ready", ready, m == N + 1);
        check("read_data", read_data, exp_rd);
        if (m >= 1 && m <= N) begin
          int b;
          b = (m - 1) / W;
          check("sram_addr", sram_addr, 18'(widx(maddr) * 2 + b));
          check("we_n", sram_we_n, !mop_wr);
          check("oe_n", sram_oe_n, mop_wr);
          if (mop_wr) check("sram_wdata", sram_wdata, 16'(mdata >> (b * 16)));
        end else begin
          check("we_n_idle", sram_we_n, 1'b1);
          check("oe_n_idle", sram_oe_n, 1'b1);
        end
      end
    end
  end

  logic        log_ready [0:63];
  logic        log_we    [0:63];
  logic        log_oe    [0:63];
  logic [17:0] log_addr  [0:63];
  logic [15:0] log_wdata [0:63];
  logic [31:0] log_rd    [0:63];

  // Entered at posedge+1 of cycle 0; returns at posedge+1 of the cycle after ready.
  task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input int drop_at, output int rc);
    rc = -1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    for (int c = 0; c < 40; c++) begin
      if (c == drop_at) begin
        wr_en = 0;
        rd_en = 0;
      end
      @(negedge clk);
      log_ready[c] = ready;
      log_we[c]    = sram_we_n;
      log_oe[c]    = sram_oe_n;
      log_addr[c]  = sram_addr;
      log_wdata[c] = sram_wdata;
      log_rd[c]    = read_data;
      if (c > 0 && ready) begin
        rc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (rc < 0) check("op_timeout", ready, 1'b1);
    @(posedge clk); #1;
    wr_en = 0;
    rd_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, rc2;
    logic ok_we, ok_oe;
    rst = 0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr2 = 0; rd2 = 0; addr2 = 0; wdata2 = 0;

    // 1: asynchronous reset before any clock edge
    #2 rst = 1;
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", sram_addr, 18'h0);
    check("rst_sram_wdata", sram_wdata, 16'h0);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_ready2", ready2, 1'b1);
    @(posedge clk); #1;
    rst = 0;
    model_on = 1;

    // 2: write 0xDEADBEEF to 1028
    run_op(1, 0, 32'd1028, 32'hDEADBEEF, -1, rc);
    check("wr_ready_cycle", rc, 7);
    check("wr_c0_ready", log_ready[0], 1'b0);
    check("wr_c6_ready", log_ready[6], 1'b0);
    for (int c = 1; c <= 3; c++) begin
      check("wr_b0_addr", log_addr[c], 18'd2);
      check("wr_b0_data", log_wdata[c], 16'hBEEF);
      check("wr_b0_we", log_we[c], 1'b0);
    end
    for (int c = 4; c <= 6; c++) begin
      check("wr_b1_addr", log_addr[c], 18'd3);
      check("wr_b1_data", log_wdata[c], 16'hDEAD);
      check("wr_b1_we", log_we[c], 1'b0);
    end
    check("wr_c7_we", log_we[7], 1'b1);

    // 3: read back 1028
    run_op(0, 1, 32'd1028, 32'h0, -1, rc);
    check("rd_ready_cycle", rc, 7);
    check("rd_data", log_rd[7], 32'hDEADBEEF);
    ok_oe = 1; ok_we = 1;
    for (int c = 1; c <= 6; c++) begin
      if (log_oe[c] !== 1'b0) ok_oe = 0;
      if (log_we[c] !== 1'b1) ok_we = 0;
    end
    check("rd_oe_low_1_6", ok_oe, 1'b1);
    check("rd_we_high_1_6", ok_we, 1'b1);
    check("rd_oe_c7", log_oe[7], 1'b1);

    // 4: back-to-back write then read of 1024
    run_op(1, 0, 32'd1024, 32'h12345678, -1, rc);
    run_op(0, 1, 32'd1024, 32'h0, -1, rc2);
    check("b2b_total_cycles", rc + 1 + rc2 + 1, 16);
    check("b2b_rd_data", log_rd[7], 32'h12345678);

    // 5: simultaneous request is a write; then a dropped request still completes
    run_op(1, 1, 32'd1032, 32'hA5A55A5A, -1, rc);
    check("sim_ready_cycle", rc, 7);
    check("sim_we_c1", log_we[1], 1'b0);
    check("sim_oe_c1", log_oe[1], 1'b1);
    check("sim_rd_unchanged", log_rd[7], 32'h12345678);
    run_op(1, 0, 32'd1036, 32'h0F0F0F0F, 2, rc);
    check("drop_ready_cycle", rc, 7);
    run_op(0, 1, 32'd1032, 32'h0, -1, rc);
    check("sim_readback", log_rd[7], 32'hA5A55A5A);

    // 6a: reset in cycle 4 of a write
    wr_en = 1; address = 32'd1040; write_data = 32'h11112222;
    repeat (4) @(posedge clk);
    #3 rst = 1;
    #1;
    check("midrst_we_n", sram_we_n, 1'b1);
    check("midrst_oe_n", sram_oe_n, 1'b1);
    check("midrst_addr", sram_addr, 18'h0);
    check("midrst_wdata", sram_wdata, 16'h0);
    check("midrst_read_data", read_data, 32'h0);
    wr_en = 0;
    #1;
    check("midrst_idle_ready", ready, 1'b1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // 6b: 32-bit SRAM, single wait cycle
    wr2 = 1; addr2 = 32'd1028; wdata2 = 32'h0BADF00D;
    @(negedge clk);
    check("p_wr_c0_ready", ready2, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("p_wr_c1_ready", ready2, 1'b0);
    check("p_wr_c1_we", we2, 1'b0);
    check("p_wr_c1_oe", oe2, 1'b1);
    check("p_wr_c1_addr", sram_addr2, 18'd1);
    check("p_wr_c1_data", sram_wdata2, 32'h0BADF00D);
    @(posedge clk); #1;
    @(negedge clk);
    check("p_wr_c2_ready", ready2, 1'b1);
    check("p_wr_c2_we", we2, 1'b1);
    @(posedge clk); #1;
    wr2 = 0; rd2 = 1;
    @(negedge clk);
    check("p_rd_c0_ready", ready2, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("p_rd_c1_oe", oe2, 1'b0);
    check("p_rd_c1_we", we2, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("p_rd_c2_ready", ready2, 1'b1);
    check("p_rd_c2_data", rdata_out2, 32'hCAFEF00D);
    @(posedge clk); #1;
    rd2 = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
